pc_sequencer: RTL and testbench

- Next-PC controller for the single-cycle CPU; drives the PC register's Target and Halt inputs.
- Selects the next address each cycle: sequential, branch, jump, call or return.
- Owns a small return-address stack and a halt/fault state machine.
- Counts retired instructions; sits between decode/control and the PC register.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/ras_stack.sv | 71 +++++++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the next-PC sequencer: FSM states, next-PC source
// select and the default address width.
package pc_seq_pkg;

   localparam int PC_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } seq_state_e;

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_BR   = 3'd1,
      SEL_JMP  = 3'd2,
      SEL_RET  = 3'd3,
      SEL_HOLD = 3'd4
   } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: small LIFO with a combinational top-of-stack read so
// a return can redirect the PC in the same cycle it is decoded.
module ras_stack #(
   parameter int RAS_DEPTH = 4,
   parameter int PC_WIDTH  = 16
) (
   input  logic                       clk_i,
   input  logic                       init_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [PC_WIDTH-1:0]        din_i,
   output logic [PC_WIDTH-1:0]        dout_o,
   output logic [$clog2(RAS_DEPTH):0] depth_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(RAS_DEPTH);
   localparam int DW = AW + 1;

   logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [DW-1:0]       depth_q;
   logic [DW-1:0]       depth_d;
   logic [AW-1:0]       wr_idx;
   logic [AW-1:0]       rd_idx;
   logic                do_push;
   logic                do_pop;

   assign full_o  = (depth_q == DW'(RAS_DEPTH));
   assign empty_o = (depth_q == '0);

   // Guard against overflow/underflow here too, so the stack can never
   // corrupt itself even if the caller misbehaves. Push wins over pop.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o && !push_i;

   // Depth is a power of two, so the low bits of the depth index the array
   // directly; at depth 0 the read index wraps, but dout is unused then.
   assign wr_idx  = depth_q[AW-1:0];
   assign rd_idx  = wr_idx - AW'(1);
   assign dout_o  = mem_q[rd_idx];
   assign depth_o = depth_q;

   // Next occupancy from the qualified push/pop requests.
   always_comb begin
      depth_d = depth_q;
      if (do_push) begin
         depth_d = depth_q + DW'(1);
      end else if (do_pop) begin
         depth_d = depth_q - DW'(1);
      end
   end

   // Occupancy register; contents are don't-care after init so only the
   // depth is cleared.
   always_ff @(posedge clk_i) begin
      if (init_i) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Entry storage: a push writes the slot just above the current top.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_idx] <= din_i;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks sequential/branch/jump/call/return targets,
// owns the return-address stack, the RUN/HALTED/FAULT machine and the
// retired-instruction counter. Target and Halt are combinational.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEF,
   parameter int RAS_DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       Init,
   input  logic [PC_WIDTH-1:0]        Count,
   input  logic                       Branch,
   input  logic [PC_WIDTH-1:0]        BrOffset,
   input  logic                       Jump,
   input  logic                       Call,
   input  logic                       Ret,
   input  logic [PC_WIDTH-1:0]        JumpAddr,
   input  logic                       HaltInstr,
   input  logic                       Stall,
   input  logic                       Resume,
   output logic [PC_WIDTH-1:0]        Target,
   output logic                       Halt,
   output logic                       Halted,
   output logic                       Fault,
   output logic [$clog2(RAS_DEPTH):0] RasDepth,
   output logic [15:0]                RetireCnt
);

   seq_state_e          state_q;
   seq_state_e          state_d;
   pc_sel_e             sel;
   logic                hold_req;
   logic                push_req;
   logic                pop_req;
   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] br_pc;
   logic [PC_WIDTH-1:0] ras_top;
   logic                ras_full;
   logic                ras_empty;
   logic [15:0]         retire_cnt_q;
   logic [15:0]         retire_cnt_d;

   ras_stack #(
      .RAS_DEPTH (RAS_DEPTH),
      .PC_WIDTH  (PC_WIDTH)
   ) u_ras (
      .clk_i   (CLK),
      .init_i  (Init),
      .push_i  (push_req),
      .pop_i   (pop_req),
      .din_i   (seq_pc),
      .dout_o  (ras_top),
      .depth_o (RasDepth),
      .full_o  (ras_full),
      .empty_o (ras_empty)
   );

   // Both adders wrap naturally at PC_WIDTH bits.
   assign seq_pc = Count + PC_WIDTH'(1);
   assign br_pc  = seq_pc + BrOffset;

   // State register; Init forces RUN regardless of anything else.
   always_ff @(posedge CLK) begin
      if (Init) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: halt instruction parks in HALTED, stack misuse is a sticky
   // FAULT, Resume is the only way out of HALTED.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (!Stall) begin
               if (HaltInstr) begin
                  state_d = HALTED;
               end else if (Ret) begin
                  if (ras_empty) state_d = FAULT;
               end else if (Call) begin
                  if (ras_full) state_d = FAULT;
               end
            end
         end
         HALTED: begin
            if (Resume) state_d = RUN;
         end
         default: state_d = FAULT;
      endcase
   end

   // Output decode: priority HaltInstr > Ret > Call > Jump > Branch > seq.
   // Any hold keeps the PC on the current instruction.
   always_comb begin
      sel      = SEL_SEQ;
      hold_req = 1'b0;
      push_req = 1'b0;
      pop_req  = 1'b0;
      if (!Init) begin
         case (state_q)
            RUN: begin
               if (Stall || HaltInstr) begin
                  sel      = SEL_HOLD;
                  hold_req = 1'b1;
               end else if (Ret) begin
                  if (ras_empty) begin
                     sel      = SEL_HOLD;
                     hold_req = 1'b1;
                  end else begin
                     sel     = SEL_RET;
                     pop_req = 1'b1;
                  end
               end else if (Call) begin
                  if (ras_full) begin
                     sel      = SEL_HOLD;
                     hold_req = 1'b1;
                  end else begin
                     sel      = SEL_JMP;
                     push_req = 1'b1;
                  end
               end else if (Jump) begin
                  sel = SEL_JMP;
               end else if (Branch) begin
                  sel = SEL_BR;
               end
            end
            HALTED: begin
               if (!Resume) begin
                  sel      = SEL_HOLD;
                  hold_req = 1'b1;
               end
            end
            default: begin
               sel      = SEL_HOLD;
               hold_req = 1'b1;
            end
         endcase
      end
   end

   // Next-PC mux driven by the decoded select.
   always_comb begin
      case (sel)
         SEL_SEQ: Target = seq_pc;
         SEL_BR:  Target = br_pc;
         SEL_JMP: Target = JumpAddr;
         SEL_RET: Target = ras_top;
         default: Target = Count;
      endcase
   end

   assign Halt   = hold_req;
   assign Halted = (state_q == HALTED);
   assign Fault  = (state_q == FAULT);

   // An instruction retires on every edge where the PC is allowed to advance.
   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (!hold_req) retire_cnt_d = retire_cnt_q + 16'd1;
   end

   // Retire counter register, cleared by Init.
   always_ff @(posedge CLK) begin
      if (Init) begin
         retire_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver applies stimulus and pushes
// the expected outputs from a behavioural model; a monitor compares them.
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        Init = 1'b0;
   logic [15:0] Count = '0;
   logic        Branch = 1'b0;
   logic [15:0] BrOffset = '0;
   logic        Jump = 1'b0;
   logic        Call = 1'b0;
   logic        Ret = 1'b0;
   logic [15:0] JumpAddr = '0;
   logic        HaltInstr = 1'b0;
   logic        Stall = 1'b0;
   logic        Resume = 1'b0;
   logic [15:0] Target;
   logic        Halt;
   logic        Halted;
   logic        Fault;
   logic [2:0]  RasDepth;
   logic [15:0] RetireCnt;

   pc_sequencer #(.PC_WIDTH(16), .RAS_DEPTH(4)) dut (
      .CLK       (CLK),
      .Init      (Init),
      .Count     (Count),
      .Branch    (Branch),
      .BrOffset  (BrOffset),
      .Jump      (Jump),
      .Call      (Call),
      .Ret       (Ret),
      .JumpAddr  (JumpAddr),
      .HaltInstr (HaltInstr),
      .Stall     (Stall),
      .Resume    (Resume),
      .Target    (Target),
      .Halt      (Halt),
      .Halted    (Halted),
      .Fault     (Fault),
      .RasDepth  (RasDepth),
      .RetireCnt (RetireCnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        init, br, jmp, call, ret, hi, stall, resume;
      logic [15:0] count, off, jaddr;
   } stim_t;

   typedef struct {
      logic [15:0] target;
      logic        halt;
      logic        halted;
      logic        fault;
      int          depth;
      logic [15:0] retire;
      bit          known;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn = 0;

   // Reference model state: mode 0=running, 1=halted, 2=faulted.
   int          m_mode = 0;
   logic [15:0] m_stack[$];
   logic [15:0] m_retire = '0;
   bit          m_known = 0;
   logic [15:0] last_target = '0;

   function automatic stim_t nop(input logic [15:0] c);
      stim_t s;
      s.init = 0; s.br = 0; s.jmp = 0; s.call = 0; s.ret = 0;
      s.hi = 0; s.stall = 0; s.resume = 0;
      s.count = c; s.off = '0; s.jaddr = '0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      exp_t        e;
      logic [15:0] tgt;
      logic        hold;
      int          nmode;
      @(posedge CLK);
      #1;
      Init = s.init; Count = s.count; Branch = s.br; BrOffset = s.off;
      Jump = s.jmp; Call = s.call; Ret = s.ret; JumpAddr = s.jaddr;
      HaltInstr = s.hi; Stall = s.stall; Resume = s.resume;

      e.halted = (m_mode == 1);
      e.fault  = (m_mode == 2);
      e.depth  = m_stack.size();
      e.retire = m_retire;
      e.known  = m_known;

      tgt   = s.count;
      hold  = 1'b1;
      nmode = m_mode;
      if (s.init) begin
         tgt = s.count + 16'd1; hold = 1'b0;
      end else if (m_mode == 0) begin
         if (s.stall) begin
            hold = 1'b1;
         end else if (s.hi) begin
            nmode = 1;
         end else if (s.ret) begin
            if (m_stack.size() > 0) begin
               tgt = m_stack.pop_back(); hold = 1'b0;
            end else begin
               nmode = 2;
            end
         end else if (s.call) begin
            if (m_stack.size() < 4) begin
               m_stack.push_back(s.count + 16'd1);
               tgt = s.jaddr; hold = 1'b0;
            end else begin
               nmode = 2;
            end
         end else if (s.jmp) begin
            tgt = s.jaddr; hold = 1'b0;
         end else if (s.br) begin
            tgt = s.count + 16'd1 + s.off; hold = 1'b0;
         end else begin
            tgt = s.count + 16'd1; hold = 1'b0;
         end
      end else if (m_mode == 1 && s.resume) begin
         tgt = s.count + 16'd1; hold = 1'b0; nmode = 0;
      end
      e.target = tgt;
      e.halt   = hold;
      exp_q.push_back(e);
      last_target = tgt;

      if (s.init) begin
         m_mode = 0; m_stack.delete(); m_retire = '0; m_known = 1;
      end else begin
         m_mode = nmode;
         if (!hold) m_retire = m_retire + 16'd1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s txn=%0d actual=%0h required=%0h", name, txn, act, req);
      end
   endtask

   // Monitor: DUT presents one response per cycle; compare mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn %0d cnt=%h tgt=%h halt=%b halted=%b fault=%b depth=%0d retire=%0d",
                     txn, Count, Target, Halt, Halted, Fault, RasDepth, RetireCnt);
            chk("Target", 32'(Target), 32'(e.target));
            chk("Halt", 32'(Halt), 32'(e.halt));
            if (e.known) begin
               chk("Halted", 32'(Halted), 32'(e.halted));
               chk("Fault", 32'(Fault), 32'(e.fault));
               chk("RasDepth", 32'(RasDepth), 32'(e.depth));
               chk("RetireCnt", 32'(RetireCnt), 32'(e.retire));
            end
            txn++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog txn=%0d actual=timeout required=finish", txn);
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      // Init, then sequential run and wrap
      s = nop(16'h0000); s.init = 1; drive(s);
      for (int i = 0; i < 4; i++) drive(nop(16'(i)));
      drive(nop(16'hFFFF));
      // Branch, and jump beating branch
      s = nop(16'h0010); s.br = 1; s.off = 16'hFFFE; drive(s);
      s = nop(16'h000F); s.br = 1; s.off = 16'h0005; s.jmp = 1; s.jaddr = 16'h0200; drive(s);
      // Call then return
      s = nop(16'h0020); s.call = 1; s.jaddr = 16'h0100; drive(s);
      drive(nop(16'h0100));
      s = nop(16'h0105); s.ret = 1; s.call = 1; s.jaddr = 16'h0777; drive(s);
      drive(nop(16'h0021));
      // Overflow: four calls fill, fifth faults
      for (int i = 0; i < 5; i++) begin
         s = nop(16'h0040 + 16'(i)); s.call = 1; s.jaddr = 16'h0040 + 16'(i + 1); drive(s);
      end
      drive(nop(16'h0044));
      s = nop(16'h0044); s.resume = 1; s.jmp = 1; s.jaddr = 16'h1234; drive(s);
      s = nop(16'h0044); s.init = 1; drive(s);
      drive(nop(16'h0045));
      // Underflow
      s = nop(16'h0050); s.ret = 1; drive(s);
      drive(nop(16'h0050));
      s = nop(16'h0050); s.init = 1; drive(s);
      // Halt / resume
      s = nop(16'h0030); s.hi = 1; drive(s);
      s = nop(16'h0030); s.call = 1; s.jaddr = 16'h0999; drive(s);
      s = nop(16'h0030); s.resume = 1; s.stall = 1; drive(s);
      drive(nop(16'h0031));
      // Stall with call
      s = nop(16'h0060); s.stall = 1; s.call = 1; s.jaddr = 16'h0070; drive(s);
      drive(nop(16'h0061));
      // Init while halted with depth 2
      s = nop(16'h0080); s.call = 1; s.jaddr = 16'h0090; drive(s);
      s = nop(16'h0090); s.call = 1; s.jaddr = 16'h00A0; drive(s);
      s = nop(16'h00A0); s.hi = 1; drive(s);
      drive(nop(16'h00A0));
      s = nop(16'h00A0); s.init = 1; drive(s);
      drive(nop(16'h00A1));
      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         s = nop(($urandom_range(3) != 0) ? last_target : 16'($urandom));
         s.init   = ($urandom_range(63) == 0);
         s.br     = ($urandom_range(3) == 0);
         s.jmp    = ($urandom_range(5) == 0);
         s.call   = ($urandom_range(5) == 0);
         s.ret    = ($urandom_range(5) == 0);
         s.hi     = ($urandom_range(15) == 0);
         s.stall  = ($urandom_range(7) == 0);
         s.resume = ($urandom_range(3) == 0);
         s.off    = 16'($urandom);
         s.jaddr  = 16'($urandom);
         drive(s);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      @(posedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
